// File: rtl/dual_port_memory_if.sv
// Request/acknowledge signals shared by the CPU (master) and the memory responder (slave).
// The bidirectional port-2 data bus is a plain inout on the responder and is not carried here.
interface dual_port_memory_if #(
    parameter int WORD_SIZE = 16
);
    logic                 readM1;
    logic [WORD_SIZE-1:0] address1;
    logic [WORD_SIZE-1:0] data1;
    logic                 ack1;
    logic                 readM2;
    logic                 writeM2;
    logic [WORD_SIZE-1:0] address2;
    logic                 ack2;

    modport master (
        output readM1, address1, readM2, writeM2, address2,
        input  data1, ack1, ack2
    );

    modport slave (
        input  readM1, address1, readM2, writeM2, address2,
        output data1, ack1, ack2
    );
endinterface

// File: rtl/dual_port_memory.sv
// Fixed-latency two-port memory responder: port 1 is a read-only fetch port, port 2 reads/writes
// through a tristate bus. Each port has its own IDLE/BUSY/DONE handshake over one shared array.
module dual_port_memory #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dual_port_memory_if.slave    bus,
    inout  wire [WORD_SIZE-1:0]  data2
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
    localparam bit         LAT_ONE  = (LATENCY == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    state_t               st1_q;
    logic [3:0]           cnt1_q;
    logic [ADDR_BITS-1:0] addr1_q;
    logic [WORD_SIZE-1:0] data1_q;
    logic                 ack1_q;

    state_t               st2_q;
    logic [3:0]           cnt2_q;
    logic [ADDR_BITS-1:0] addr2_q;
    logic                 op_wr2_q;
    logic [WORD_SIZE-1:0] wdata2_q;
    logic [WORD_SIZE-1:0] rdata2_q;
    logic                 drive2_q;
    logic                 ack2_q;

    logic                 req2_s;
    logic [ADDR_BITS-1:0] addr1_in_s;
    logic [ADDR_BITS-1:0] addr2_in_s;
    logic                 wr_en_s;
    logic [ADDR_BITS-1:0] wr_addr_s;
    logic [WORD_SIZE-1:0] wr_data_s;
    logic                 unused_s;

    // Upper address bits are deliberately ignored so addresses wrap modulo the depth.
    assign addr1_in_s = bus.address1[ADDR_BITS-1:0];
    assign addr2_in_s = bus.address2[ADDR_BITS-1:0];
    assign unused_s   = ^{bus.address1[WORD_SIZE-1:ADDR_BITS], bus.address2[WORD_SIZE-1:ADDR_BITS]};
    assign req2_s     = bus.readM2 | bus.writeM2;

    assign bus.data1 = data1_q;
    assign bus.ack1  = ack1_q;
    assign bus.ack2  = ack2_q;
    assign data2     = drive2_q ? rdata2_q : {WORD_SIZE{1'bz}};

    // Port-1 fetch handshake: accept, count down, read on the final edge, pulse ack.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st1_q   <= ST_IDLE;
            cnt1_q  <= 4'd0;
            addr1_q <= {ADDR_BITS{1'b0}};
            data1_q <= {WORD_SIZE{1'b0}};
            ack1_q  <= 1'b0;
        end else begin
            case (st1_q)
                ST_IDLE: begin
                    ack1_q <= 1'b0;
                    if (bus.readM1) begin
                        addr1_q <= addr1_in_s;
                        cnt1_q  <= CNT_LOAD;
                        if (LAT_ONE) begin
                            data1_q <= mem_q[addr1_in_s];
                            ack1_q  <= 1'b1;
                            st1_q   <= ST_DONE;
                        end else begin
                            st1_q   <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!bus.readM1) begin
                        st1_q <= ST_IDLE;
                    end else if (cnt1_q == 4'd0) begin
                        data1_q <= mem_q[addr1_q];
                        ack1_q  <= 1'b1;
                        st1_q   <= ST_DONE;
                    end else begin
                        cnt1_q  <= cnt1_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    ack1_q <= 1'b0;
                    st1_q  <= ST_IDLE;
                end
                default: begin
                    ack1_q <= 1'b0;
                    st1_q  <= ST_IDLE;
                end
            endcase
        end
    end

    // Port-2 handshake; a simultaneous read+write request is taken as a write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st2_q    <= ST_IDLE;
            cnt2_q   <= 4'd0;
            addr2_q  <= {ADDR_BITS{1'b0}};
            op_wr2_q <= 1'b0;
            wdata2_q <= {WORD_SIZE{1'b0}};
            rdata2_q <= {WORD_SIZE{1'b0}};
            drive2_q <= 1'b0;
            ack2_q   <= 1'b0;
        end else begin
            case (st2_q)
                ST_IDLE: begin
                    ack2_q   <= 1'b0;
                    drive2_q <= 1'b0;
                    if (req2_s) begin
                        addr2_q  <= addr2_in_s;
                        op_wr2_q <= bus.writeM2;
                        cnt2_q   <= CNT_LOAD;
                        if (bus.writeM2) begin
                            wdata2_q <= data2;
                        end
                        if (LAT_ONE) begin
                            ack2_q <= 1'b1;
                            st2_q  <= ST_DONE;
                            if (!bus.writeM2) begin
                                rdata2_q <= mem_q[addr2_in_s];
                                drive2_q <= 1'b1;
                            end
                        end else begin
                            st2_q  <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (!req2_s) begin
                        st2_q <= ST_IDLE;
                    end else if (cnt2_q == 4'd0) begin
                        ack2_q <= 1'b1;
                        st2_q  <= ST_DONE;
                        if (!op_wr2_q) begin
                            rdata2_q <= mem_q[addr2_q];
                            drive2_q <= 1'b1;
                        end
                    end else begin
                        cnt2_q <= cnt2_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    ack2_q   <= 1'b0;
                    drive2_q <= 1'b0;
                    st2_q    <= ST_IDLE;
                end
                default: begin
                    ack2_q   <= 1'b0;
                    drive2_q <= 1'b0;
                    st2_q    <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-commit decode: the final BUSY edge of a surviving write, or acceptance when LATENCY is 1.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = addr2_q;
        wr_data_s = wdata2_q;
        if ((st2_q == ST_BUSY) && req2_s && (cnt2_q == 4'd0) && op_wr2_q) begin
            wr_en_s = 1'b1;
        end else if (LAT_ONE && (st2_q == ST_IDLE) && bus.writeM2) begin
            wr_en_s   = 1'b1;
            wr_addr_s = addr2_in_s;
            wr_data_s = data2;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Array write port; contents survive reset, and nothing commits while reset is held.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en_s) begin
            mem_q[wr_addr_s] <= wr_data_s;
        end
    end

endmodule
